difftest_step_arbiter: RTL and testbench
========================================

# difftest_step_arbiter

Shares the single difftest checker step channel between `NUM_CORES` cores. Each cycle it accumulates per-core committed-step counts and grants one core at a time in round-robin order. It issues that core's pending steps as a bounded nstep request, then waits for the checker result. It also raises sticky done/fail status and runs an optional per-core no-progress watchdog. It sits between the core-side difftest step outputs and the endpoint's nstep/result logic.

## Interface
- `NUM_CORES`, 2: number of requesting cores (≥1).
- `STEP_W`, 8: width of per-cycle step input and of request chunk.
- `ACC_W`, 16: per-core pending-step accumulator width (> `STEP_W`).
- `STUCK_W`, 32: watchdog timer/limit width.

- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `step_in`  in  `NUM_CORES*STEP_W`  per-core steps committed this cycle; core i at `[i*STEP_W +: STEP_W]`.
- `req_valid`  out  1  nstep request valid.
- `req_ready`  in  1  checker accepts request.
- `req_core`  out  `$clog2(NUM_CORES)` (min 1)  granted core index.
- `req_step`  out  `STEP_W`  steps in this request, nonzero.
- `rsp_valid`  in  1  checker result valid.
- `rsp_result`  in  8  0 = continue, 1 = done, 2 = fail, others = fail.
- `done`  out  1  sticky: a core reported done.
- `fail`  out  1  sticky: checker failure or accumulator overflow.
- `fail_core`  out  `$clog2(NUM_CORES)`  core responsible for first failure.
- `stuck_limit`  in  `STUCK_W`  watchdog limit; 0 disables.
- `stuck`  out  1  sticky watchdog trip.

## Operation
- Accumulators `acc[i]`: each cycle `acc[i] <= acc[i] + step_in[i] - sent[i]`. `sent[i]` = `req_step` on the request handshake cycle for the granted core, else 0. Simultaneous input and dequeue on the same core both apply.
- Overflow: if the sum exceeds `2^ACC_W-1`, saturate, set `fail`, and latch `fail_core` = i (lowest i if several).
- FSM states: IDLE, REQ, WAIT, HALT.
  - IDLE: if any `acc != 0`, the round-robin arbiter picks the next core after the last granted one (core 0 after reset). Latch `req_core` and `req_step = min(acc, 2^STEP_W-1)`, then go to REQ.
  - REQ: `req_valid`=1; `req_core` and `req_step` are held stable. On `req_ready`, subtract from acc and go to WAIT.
  - WAIT: on `rsp_valid`:
    - result 0 → IDLE.
    - result 1 → set `done`, go to IDLE.
    - any other value → set `fail`, latch `fail_core`, go to HALT.
  - HALT: terminal state; no requests issued, accumulators keep counting and saturate silently.
- `rsp_valid` outside WAIT is ignored.
- `fail` already set from overflow forces IDLE → HALT instead of granting.
- `done` does not stop arbitration; the endpoint decides to finish or switch workload.

## Timing
- Reset values: `req_valid`=0, `req_core`=0, `req_step`=0, `done`=0, `fail`=0, `fail_core`=0, `stuck`=0, all acc=0, state IDLE.
- Latency: step_in at cycle t → acc nonzero at t+1 → REQ/`req_valid` at t+2.
- Minimum turnaround per request: 3 cycles (REQ accepted same cycle, 1-cycle response).
- Ready may be held high permanently; valid never depends on ready.
- Round-robin pointer advances only on handshake.
- Reset mid-request drops the request and all pending steps.

## Configuration
- `DIFFTEST_STEP_ARB_STUCK_EN` defined:
  - Per-core `STUCK_W` timer clears on nonzero `step_in[i]`, else increments, saturating.
  - `stuck` sets when `stuck_limit != 0` and any timer ≥ `stuck_limit`, with 1-cycle latency after the compare.
- Undefined: timers not instantiated, `stuck` tied 0, `stuck_limit` unused.

## Structure
- Package `difftest_step_arb_pkg`: result codes `SIMV_CONT`=0, `SIMV_DONE`=1, `SIMV_FAIL`=2; FSM state enum.
- Sub-module `difftest_rr_arbiter`: request vector plus last-grant pointer in, one-hot/index grant out, purely combinational.

## Test plan
- Single core, `step_in`=3 for one cycle, ready=1, rsp=0 next cycle → one request `req_core`=0, `req_step`=3 at t+2; acc returns to 0.
- Core 0 and core 1 both pending 5 → grants alternate 0,1,0…; ready held low 4 cycles keeps `req_step`/`req_core` stable.
- acc=600, `STEP_W`=8 → requests of 255, 255, 90.
- Result 2 on core 1 → `fail`=1, `fail_core`=1, no further `req_valid` despite new steps; result 1 → `done`=1, arbitration continues.
- Drive `step_in`=255 on one core every cycle with `req_ready`=0 until acc exceeds 65535 → saturates, `fail`=1, FSM enters HALT.
- Macro defined, `stuck_limit`=10, core 1 idle → `stuck`=1 about 11 cycles after its last step; `stuck_limit`=0 → never trips.

Source files
------------

// File: rtl/difftest_step_arbiter_pkg.sv
// difftest_step_arb_pkg: shared result codes, FSM state encoding and width helper
// for the difftest step-channel arbiter.
package difftest_step_arb_pkg;

    localparam logic [7:0] SIMV_CONT = 8'd0;
    localparam logic [7:0] SIMV_DONE = 8'd1;
    localparam logic [7:0] SIMV_FAIL = 8'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HALT = 2'd3
    } arb_state_e;

    // Core index width, kept at least one bit so a single-core build still has a port.
    function automatic int core_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/difftest_step_arbiter_if.sv
// difftest_step_arbiter_if: nstep request / checker result channel.
//   req_valid, req_core, req_step : request from arbiter (master) to checker
//   req_ready                     : checker accepts the request
//   rsp_valid, rsp_result         : checker verdict back to the arbiter
interface difftest_step_arbiter_if
    import difftest_step_arb_pkg::*;
#(
    parameter int NUM_CORES = 2,
    parameter int STEP_W    = 8
);
    logic                         req_valid;
    logic                         req_ready;
    logic [core_w(NUM_CORES)-1:0] req_core;
    logic [STEP_W-1:0]            req_step;
    logic                         rsp_valid;
    logic [7:0]                   rsp_result;

    modport master (
        output req_valid, req_core, req_step,
        input  req_ready, rsp_valid, rsp_result
    );

    modport slave (
        input  req_valid, req_core, req_step,
        output req_ready, rsp_valid, rsp_result
    );
endinterface

// File: rtl/difftest_step_arbiter_rr_arbiter.sv
// difftest_rr_arbiter: combinational round-robin pick.
//   req  : per-core request vector
//   last : index of the most recently granted core
//   gnt  : one-hot grant, idx : granted index, any : some request present
// Priority starts just above `last` and wraps around to core 0.
module difftest_rr_arbiter #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         any
);
    always_comb begin
        idx = '0;
        any = |req;
        for (int i = N - 1; i >= 0; i--)
            if (req[i]) idx = W'(i);
        // second pass overrides with the lowest requester above `last`, if any
        for (int i = N - 1; i >= 0; i--)
            if (req[i] && W'(i) > last) idx = W'(i);
        gnt = any ? (N'(1) << idx) : '0;
    end
endmodule

// File: rtl/difftest_step_arbiter.sv
// difftest_step_arbiter: shares one difftest nstep checker channel between cores.
//   clock, reset_n   : clock and asynchronous active-low reset
//   step_in          : per-core committed steps this cycle, core i at [i*STEP_W +: STEP_W]
//   bus (master)     : nstep request out, checker result in
//   done, fail       : sticky status; fail_core names the first failing core
//   stuck_limit/stuck: per-core no-progress watchdog (0 disables)
// Optional feature macro: DIFFTEST_STEP_ARB_STUCK_EN enables the watchdog timers;
// without it `stuck` is constant 0.
module difftest_step_arbiter
    import difftest_step_arb_pkg::*;
#(
    parameter int NUM_CORES = 2,
    parameter int STEP_W    = 8,
    parameter int ACC_W     = 16,
    parameter int STUCK_W   = 32
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NUM_CORES*STEP_W-1:0]   step_in,
    difftest_step_arbiter_if.master       bus,
    output logic                          done,
    output logic                          fail,
    output logic [core_w(NUM_CORES)-1:0]  fail_core,
    input  logic [STUCK_W-1:0]            stuck_limit,
    output logic                          stuck
);
    localparam int CORE_W = core_w(NUM_CORES);
    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_REQ  = ST_REQ;
    localparam logic [1:0] S_WAIT = ST_WAIT;
    localparam logic [1:0] S_HALT = ST_HALT;
    localparam logic [ACC_W-1:0] STEP_MAX = ACC_W'({STEP_W{1'b1}});

    logic [1:0]           state;
    logic [ACC_W-1:0]     acc    [NUM_CORES];
    logic [ACC_W-1:0]     acc_nx [NUM_CORES];
    logic [ACC_W:0]       sum    [NUM_CORES];
    logic [NUM_CORES-1:0] pend, ovf, gnt;
    logic [CORE_W-1:0]    last, gnt_idx, ovf_core;
    logic                 gnt_any, hs, rsp_hit, rsp_bad;
    logic [ACC_W-1:0]     sel_acc;
    logic [STEP_W-1:0]    step_cap;

    assign bus.req_valid = state == S_REQ;
    assign hs            = state == S_REQ && bus.req_ready;
    assign rsp_hit       = state == S_WAIT && bus.rsp_valid;
    assign rsp_bad       = rsp_hit && bus.rsp_result != SIMV_CONT && bus.rsp_result != SIMV_DONE;
    assign step_cap      = sel_acc > STEP_MAX ? {STEP_W{1'b1}} : sel_acc[STEP_W-1:0];

    // Add this cycle's steps, remove what the handshake dequeued; one extra bit catches overflow.
    always_comb begin
        sum      = '{default: '0};
        acc_nx   = '{default: '0};
        ovf      = '0;
        ovf_core = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            sum[i]    = {1'b0, acc[i]} + (ACC_W+1)'(step_in[i*STEP_W +: STEP_W])
                      - ((hs && bus.req_core == CORE_W'(i)) ? (ACC_W+1)'(bus.req_step) : '0);
            ovf[i]    = sum[i][ACC_W];
            acc_nx[i] = ovf[i] ? '1 : sum[i][ACC_W-1:0];
            if (ovf[i]) ovf_core = CORE_W'(i);
        end
    end

    always_comb begin
        pend = '0;
        for (int i = 0; i < NUM_CORES; i++)
            pend[i] = acc[i] != '0;
    end

    always_comb begin
        sel_acc = '0;
        for (int i = 0; i < NUM_CORES; i++)
            sel_acc = sel_acc | (gnt[i] ? acc[i] : '0);
    end

    difftest_rr_arbiter #(.N(NUM_CORES), .W(CORE_W)) u_rr (
        .req  (pend),
        .last (last),
        .gnt  (gnt),
        .idx  (gnt_idx),
        .any  (gnt_any)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            last         <= CORE_W'(NUM_CORES - 1);
            bus.req_core <= '0;
            bus.req_step <= '0;
            done         <= 1'b0;
            fail         <= 1'b0;
            fail_core    <= '0;
            for (int i = 0; i < NUM_CORES; i++) acc[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) acc[i] <= acc_nx[i];
            if (rsp_hit && bus.rsp_result == SIMV_DONE) done <= 1'b1;
            // only the first failure is recorded; overflow wins a same-cycle tie
            if (!fail && (|ovf || rsp_bad)) begin
                fail      <= 1'b1;
                fail_core <= |ovf ? ovf_core : bus.req_core;
            end
            case (state)
                S_IDLE: begin
                    if (fail) state <= S_HALT;
                    else if (gnt_any) begin
                        state        <= S_REQ;
                        bus.req_core <= gnt_idx;
                        bus.req_step <= step_cap;
                    end
                end
                S_REQ: begin
                    if (bus.req_ready) begin
                        state <= S_WAIT;
                        last  <= bus.req_core;
                    end
                end
                S_WAIT: if (bus.rsp_valid) state <= rsp_bad ? S_HALT : S_IDLE;
                default: state <= S_HALT;
            endcase
        end
    end

`ifdef DIFFTEST_STEP_ARB_STUCK_EN
    logic [STUCK_W-1:0] timer [NUM_CORES];
    logic               hit;

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NUM_CORES; i++)
            if (timer[i] >= stuck_limit) hit = 1'b1;
        hit = hit && stuck_limit != '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stuck <= 1'b0;
            for (int i = 0; i < NUM_CORES; i++) timer[i] <= '0;
        end else begin
            stuck <= stuck | hit;
            for (int i = 0; i < NUM_CORES; i++)
                timer[i] <= step_in[i*STEP_W +: STEP_W] != '0 ? '0 : (&timer[i] ? timer[i] : timer[i] + 1'b1);
        end
    end
`else
    // watchdog absent: the limit is folded in only so it is not a dangling input
    assign stuck = 1'b0 & (|stuck_limit);
`endif
endmodule

// File: tb/tb_difftest_step_arbiter.sv
// tb_difftest_step_arbiter: directed scoreboard bench for difftest_step_arbiter.
module tb_difftest_step_arbiter;
    import difftest_step_arb_pkg::*;

    localparam int NC = 2, SW = 8, AW = 16, TW = 32;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic [NC*SW-1:0] step_in;
    logic             done, fail, stuck;
    logic [0:0]       fail_core;
    logic [TW-1:0]    stuck_limit;

    difftest_step_arbiter_if #(.NUM_CORES(NC), .STEP_W(SW)) bus ();

    difftest_step_arbiter #(.NUM_CORES(NC), .STEP_W(SW), .ACC_W(AW), .STUCK_W(TW)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .step_in     (step_in),
        .bus         (bus),
        .done        (done),
        .fail        (fail),
        .fail_core   (fail_core),
        .stuck_limit (stuck_limit),
        .stuck       (stuck)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [0:0] core;
        logic [7:0] step;
    } req_t;

    req_t       exp_q[$];
    logic [7:0] rsp_q[$];
    req_t       e;
    int         n_vec = 0;
    int         n_err = 0;
    logic       rsp_busy = 1'b0;

    // monitor: every accepted request is checked against the next expected one
    always @(negedge clock) begin
        if (bus.req_valid && bus.req_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_req: got core %0d step %0d, required no request", bus.req_core, bus.req_step);
            end else begin
                e = exp_q.pop_front();
                if (bus.req_core !== e.core || bus.req_step !== e.step) begin
                    n_err++;
                    $display("FAIL req: got core %0d step %0d, required core %0d step %0d",
                             bus.req_core, bus.req_step, e.core, e.step);
                end
            end
        end
    end

    // checker model: answers each accepted request one cycle later
    initial begin
        bus.rsp_valid  = 1'b0;
        bus.rsp_result = 8'd0;
        forever begin
            @(negedge clock);
            if (bus.req_valid && bus.req_ready) begin
                rsp_busy = 1'b1;
                @(posedge clock);
                #1;
                bus.rsp_valid  = 1'b1;
                bus.rsp_result = rsp_q.size() != 0 ? rsp_q.pop_front() : 8'd0;
                @(posedge clock);
                #1;
                bus.rsp_valid = 1'b0;
                rsp_busy      = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach the end, required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, expv);
        end
    endtask

    task automatic steps(input int c0, input int c1);
        step_in = {8'(c1), 8'(c0)};
    endtask

    task automatic expect_req(input int core, input int step, input int rsp);
        exp_q.push_back({1'(core), 8'(step)});
        rsp_q.push_back(8'(rsp));
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || rsp_busy || bus.req_valid) && k < 200) begin
            tick();
            k++;
        end
        chk({name, "_drained"}, 32'(k < 200), 1);
        tick();
        tick();
    endtask

    task automatic quiet(input string name, input int n);
        int seen;
        seen = 0;
        repeat (n) begin
            if (bus.req_valid) seen++;
            tick();
        end
        chk(name, seen, 0);
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        step_in       = '0;
        bus.req_ready = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        step_in       = '0;
        bus.req_ready = 1'b0;
        stuck_limit   = '0;
        tick();
        tick();
        chk("rst_req_valid", bus.req_valid, 0);
        chk("rst_req_core", bus.req_core, 0);
        chk("rst_req_step", bus.req_step, 0);
        chk("rst_done", done, 0);
        chk("rst_fail", fail, 0);
        chk("rst_fail_core", fail_core, 0);
        chk("rst_stuck", stuck, 0);
        reset_n = 1'b1;
        tick();

        // single request, valid two cycles after the step
        bus.req_ready = 1'b1;
        expect_req(0, 3, 0);
        steps(3, 0);
        tick();
        steps(0, 0);
        chk("t1_valid_early", bus.req_valid, 0);
        tick();
        chk("t1_valid", bus.req_valid, 1);
        chk("t1_core", bus.req_core, 0);
        chk("t1_step", bus.req_step, 3);
        drain("t1");
        quiet("t1_acc_empty", 5);

        // two cores pending: last grant was core 0, so core 1 goes first; stall holds the request
        bus.req_ready = 1'b0;
        expect_req(1, 5, 0);
        expect_req(0, 5, 0);
        steps(5, 5);
        tick();
        steps(0, 0);
        tick();
        repeat (4) begin
            chk("t2_hold", {bus.req_valid, 7'(bus.req_core), bus.req_step}, {1'b1, 7'd1, 8'd5});
            tick();
        end
        bus.req_ready = 1'b1;
        drain("t2");

        // core 0 accumulates 600 while core 1's request stalls -> chunks 255, 255, 90
        bus.req_ready = 1'b0;
        expect_req(1, 1, 0);
        expect_req(0, 255, 0);
        expect_req(0, 255, 0);
        expect_req(0, 90, 0);
        steps(0, 1);
        tick();
        steps(0, 0);
        tick();
        steps(200, 0);
        tick();
        tick();
        tick();
        steps(0, 0);
        bus.req_ready = 1'b1;
        drain("t3");

        // done does not stop arbitration; a failure halts it
        expect_req(0, 4, 1);
        steps(4, 0);
        tick();
        steps(0, 0);
        chk("t4_done_pre", done, 0);
        drain("t4a");
        chk("t4_done", done, 1);
        chk("t4_fail_pre", fail, 0);
        expect_req(1, 6, 2);
        steps(0, 6);
        tick();
        steps(0, 0);
        drain("t4b");
        chk("t4_fail", fail, 1);
        chk("t4_fail_core", fail_core, 1);
        chk("t4_done_kept", done, 1);
        steps(9, 9);
        tick();
        steps(0, 0);
        quiet("t4_halted", 12);

        // reset while a request is pending drops it and the accumulated steps
        do_reset();
        steps(7, 0);
        tick();
        steps(0, 0);
        tick();
        chk("t5_pending", bus.req_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("t5_async_drop", bus.req_valid, 0);
        tick();
        reset_n       = 1'b1;
        bus.req_ready = 1'b1;
        quiet("t5_dropped", 8);
        chk("t5_fail", fail, 0);
        chk("t5_done", done, 0);

        // accumulator overflow: 255*257 = 65535 fits, the 258th add overflows
        bus.req_ready = 1'b0;
        steps(255, 0);
        repeat (257) tick();
        chk("t6_fail_pre", fail, 0);
        tick();
        chk("t6_fail", fail, 1);
        chk("t6_fail_core", fail_core, 0);
        steps(0, 0);
        expect_req(0, 255, 0);
        bus.req_ready = 1'b1;
        drain("t6");
        steps(3, 3);
        tick();
        steps(0, 0);
        quiet("t6_halted", 10);

`ifdef DIFFTEST_STEP_ARB_STUCK_EN
        do_reset();
        stuck_limit = '0;
        repeat (30) tick();
        chk("t7_disabled", stuck, 0);
        do_reset();
        stuck_limit = 32'd10;
        steps(1, 1);
        tick();
        steps(1, 0);
        repeat (10) tick();
        chk("t7_stuck_pre", stuck, 0);
        tick();
        chk("t7_stuck", stuck, 1);
`else
        do_reset();
        stuck_limit = 32'd10;
        repeat (30) tick();
        chk("t7_stuck_off", stuck, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
